int_arbiter: RTL

- Interrupt controller between peripheral IRQ lines and the CPU CSR interrupt interface.
- Edge-detects NUM_SRC source lines into pending bits and masks them with a software-programmed enable register.
- Picks one pending source by round-robin, presents IntReq/IntID to the CSR, and sequences the claim / return handshake.
- One interrupt is outstanding at a time; further edges are held pending.

---
 rtl/int_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/int_arbiter.sv
// Interrupt arbiter: edge-detects source lines into pending bits, picks one
// enabled source round-robin and runs the request / claim / return handshake.
module int_arbiter #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 3
) (
  input  logic               CK,
  input  logic               RSTn,
  input  logic [NUM_SRC-1:0] SRC_IRQ,
  output logic               IntReq,
  output logic [ID_W-1:0]    IntID,
  input  logic               IntClaim,
  input  logic               IntRet,
  input  logic               CFG_WEN,
  input  logic [1:0]         CFG_ADDR,
  input  logic [31:0]        CFG_DI,
  output logic [31:0]        CFG_DO
);

  localparam int EXT = 2**ID_W;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, ACTIVE = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] src_q, src_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] en_q, en_d;
  logic [ID_W-1:0]    cur_id_q, cur_id_d;
  logic [ID_W-1:0]    last_q, last_d;

  logic [NUM_SRC-1:0] elig, edge_set, pend_clr;
  logic [EXT-1:0]     elig_ext, cur_oh;
  logic               win_vld;
  logic [ID_W-1:0]    win_id;
  logic               wr_en, wr_pend;

  assign elig     = pend_q & en_q;
  assign elig_ext = EXT'(elig);
  assign edge_set = SRC_IRQ & ~src_q;
  assign wr_en    = CFG_WEN && (CFG_ADDR == 2'd0);
  assign wr_pend  = CFG_WEN && (CFG_ADDR == 2'd1);
  assign cur_oh   = EXT'(1) << cur_id_q;

  // Round-robin scan starting just after the last granted source, index kept
  // one bit wider than the ID so the wrap compare cannot overflow.
  always_comb begin
    logic [ID_W:0] idx;
    win_vld = 1'b0;
    win_id  = '0;
    idx     = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = {1'b0, last_q} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_SRC)) idx = idx - (ID_W+1)'(NUM_SRC);
      if (!win_vld && elig_ext[idx[ID_W-1:0]]) begin
        win_vld = 1'b1;
        win_id  = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_id_d = cur_id_q;
    last_d   = last_q;
    pend_clr = '0;
    src_d    = SRC_IRQ;
    en_d     = wr_en ? CFG_DI[NUM_SRC-1:0] : en_q;
    if (wr_pend) pend_clr = CFG_DI[NUM_SRC-1:0];
    case (state_q)
      IDLE: if (win_vld) begin
        cur_id_d = win_id;
        state_d  = REQ;
      end
      REQ: begin
        if (IntClaim) begin
          pend_clr = pend_clr | cur_oh[NUM_SRC-1:0];
          last_d   = cur_id_q;
          state_d  = ACTIVE;
        end else if (!elig_ext[cur_id_q]) begin
          state_d = IDLE;
        end
      end
      ACTIVE: if (IntRet) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // a new edge always survives a same-cycle clear
    pend_d = (pend_q & ~pend_clr) | edge_set;
  end

  always_ff @(posedge CK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= IDLE;
      src_q    <= '0;
      pend_q   <= '0;
      en_q     <= '0;
      cur_id_q <= '0;
      last_q   <= ID_W'(NUM_SRC-1);
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      pend_q   <= pend_d;
      en_q     <= en_d;
      cur_id_q <= cur_id_d;
      last_q   <= last_d;
    end
  end

  assign IntReq = (state_q == REQ);
  assign IntID  = cur_id_q;

  always_comb begin
    CFG_DO = '0;
    case (CFG_ADDR)
      2'd0: CFG_DO = 32'(en_q);
      2'd1: CFG_DO = 32'(pend_q);
      2'd2: CFG_DO = (32'(state_q) << 8) | 32'(cur_id_q);
      default: CFG_DO = '0;
    endcase
  end

endmodule
